// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell reused over WIDTH cycles, LSB first,
// with a start/ready/done handshake and a held result register.

module full_adder (
    output logic c,
    output logic s,
    input  logic a,
    input  logic b,
    input  logic cin
);
    assign s = a ^ b ^ cin;
    assign c = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   s_sh;
    logic               fa_s;
    logic               fa_c;

    // New sum bit enters at the MSB; written so WIDTH==1 needs no empty slice.
    function automatic logic [WIDTH-1:0] shift_in(input logic bit_in,
                                                  input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = v >> 1;
        r[WIDTH-1] = bit_in;
        return r;
    endfunction

    full_adder u_fa (
        .c   (fa_c),
        .s   (fa_s),
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    s_sh  <= shift_in(fa_s, s_sh);
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_c;
                    cnt   <= cnt + CNT_W'(1);
                    // sum/cout are only touched on the last bit so the old
                    // result stays visible for the whole operation.
                    if (cnt == LAST) begin
                        sum   <= shift_in(fa_s, s_sh);
                        cout  <= fa_c;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random bench for serial_adder_ctrl at WIDTH=64 and WIDTH=1,
// with a queue of expected {cout,sum} values popped on each done pulse.

module tb_serial_adder_ctrl;
    logic        clk = 1'b0;
    logic        rst;

    logic        start64;
    logic [63:0] a64, b64;
    logic        cin64;
    logic        ready64, busy64, done64, cout64;
    logic [63:0] sum64;

    logic        start1;
    logic [0:0]  a1, b1;
    logic        cin1;
    logic        ready1, busy1, done1, cout1;
    logic [0:0]  sum1;

    logic [64:0] q64[$];
    logic [1:0]  q1[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(64), .CNT_W(7)) dut64 (
        .clk(clk), .rst(rst), .start(start64), .a(a64), .b(b64), .cin(cin64),
        .ready(ready64), .busy(busy64), .done(done64), .sum(sum64), .cout(cout64)
    );

    serial_adder_ctrl #(.WIDTH(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [64:0] model64(input logic [63:0] x, input logic [63:0] y,
                                            input logic c);
        return {1'b0, x} + {1'b0, y} + {64'd0, c};
    endfunction

    task automatic issue64(input logic [63:0] ia, input logic [63:0] ib, input logic ic);
        check("ready before issue", 128'(ready64), 128'(1));
        a64 = ia; b64 = ib; cin64 = ic; start64 = 1'b1;
        q64.push_back(model64(ia, ib, ic));
        tick();
        start64 = 1'b0;
        check("busy after accept", 128'(busy64), 128'(1));
    endtask

    task automatic wait_done64(input int lat, input string tag);
        int n;
        logic [64:0] e;
        n = 0;
        while (done64 !== 1'b1 && n < lat + 8) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 128'(n), 128'(lat));
        e = (q64.size() > 0) ? q64.pop_front() : 'x;
        check({tag, " result"}, 128'({cout64, sum64}), 128'(e));
        tick();
        check({tag, " done single pulse"}, 128'(done64), 128'(0));
        check({tag, " ready after done"}, 128'(ready64), 128'(1));
    endtask

    initial begin
        logic [63:0] ra, rb;
        logic        rc;
        logic [64:0] prev;
        int          seen;

        rst = 1'b1;
        start64 = 1'b0; a64 = '0; b64 = '0; cin64 = 1'b0;
        start1  = 1'b0; a1  = '0; b1  = '0; cin1  = 1'b0;
        #2;
        check("reset ready", 128'(ready64), 128'(1));
        check("reset busy", 128'(busy64), 128'(0));
        check("reset done", 128'(done64), 128'(0));
        check("reset sum/cout", 128'({cout64, sum64}), 128'(0));
        check("reset w1 ready", 128'(ready1), 128'(1));
        #5 rst = 1'b0;
        tick();

        // all-ones plus one: full carry propagation
        issue64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        wait_done64(64, "ones+1");

        issue64(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
        wait_done64(64, "complement cin1");
        check("complement cin1 const", 128'({cout64, sum64}), 128'({1'b1, 64'd0}));
        issue64(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0);
        wait_done64(64, "complement cin0");
        check("complement cin0 const", 128'({cout64, sum64}), 128'({1'b0, 64'hFFFF_FFFF_FFFF_FFFF}));

        // asynchronous reset mid-cycle during RUN, with a nonzero held result
        issue64(64'd7, 64'd9, 1'b0);
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        check("async rst ready", 128'(ready64), 128'(1));
        check("async rst busy", 128'(busy64), 128'(0));
        check("async rst done", 128'(done64), 128'(0));
        check("async rst sum/cout", 128'({cout64, sum64}), 128'(0));
        void'(q64.pop_back());
        #2 rst = 1'b0;
        tick();

        // start during RUN is ignored; sum holds until the done edge
        prev = {cout64, sum64};
        issue64(64'd10, 64'd20, 1'b0);
        repeat (10) tick();
        check("sum held in RUN", 128'({cout64, sum64}), 128'(prev));
        a64 = 64'd1; b64 = 64'd1; start64 = 1'b1;
        tick();
        start64 = 1'b0; a64 = 64'hDEAD; b64 = 64'hBEEF;
        check("still busy after ignored start", 128'(busy64), 128'(1));
        wait_done64(53, "ignored start");
        check("ignored start const", 128'({cout64, sum64}), 128'(30));

        // reset at RUN cycle 30: no done, then a clean operation
        issue64(64'd100, 64'd200, 1'b1);
        repeat (29) tick();
        #2 rst = 1'b1;
        #1;
        check("abort sum/cout", 128'({cout64, sum64}), 128'(0));
        check("abort ready", 128'(ready64), 128'(1));
        void'(q64.pop_back());
        #2 rst = 1'b0;
        seen = 0;
        repeat (70) begin
            tick();
            if (done64 === 1'b1) seen++;
        end
        check("no done after abort", 128'(seen), 128'(0));
        issue64(64'd5, 64'd3, 1'b0);
        wait_done64(64, "after abort");

        // start held high: back-to-back issue every WIDTH+2 cycles
        start64 = 1'b1;
        for (int i = 0; i < 400; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            if (i == 0) begin ra = '1; rb = '1; rc = 1'b1; end
            a64 = ra; b64 = rb; cin64 = rc;
            check("w64 reissue ready", 128'(ready64), 128'(1));
            q64.push_back(model64(ra, rb, rc));
            tick();
            check("w64 reissue busy", 128'(busy64), 128'(1));
            a64 = {$urandom, $urandom};
            b64 = {$urandom, $urandom};
            cin64 = ~rc;
            wait_done64(64, "w64 random");
            if (i == 399) start64 = 1'b0;
        end

        start1 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a1 = 1'($urandom_range(0, 1));
            b1 = 1'($urandom_range(0, 1));
            cin1 = 1'($urandom_range(0, 1));
            check("w1 ready", 128'(ready1), 128'(1));
            q1.push_back(2'(a1) + 2'(b1) + 2'(cin1));
            tick();
            check("w1 busy", 128'(busy1), 128'(1));
            a1 = ~a1; b1 = ~b1;
            tick();
            check("w1 done", 128'(done1), 128'(1));
            check("w1 result", 128'({cout1, sum1}), 128'((q1.size() > 0) ? q1.pop_front() : 2'bxx));
            tick();
            check("w1 done low", 128'(done1), 128'(0));
            if (i == 999) start1 = 1'b0;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
